// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO sequencer for MULT/MULTU/DIV/DIVU that owns the HI/LO write port and merges MTHI/MTLO writes.
// When MULDIV_DIV_EARLY_EXIT_EN is defined, a divide by zero or |dividend| < |divisor| skips the iterative divide.
module muldiv_ctrl #(
   parameter int MULT_LAT = 3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start_valid,
   input  logic [1:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   input  logic        mt_we,
   input  logic        mt_hi,
   input  logic [31:0] mt_data,
   output logic        busy,
   output logic        done,
   output logic [1:0]  hilo_we,
   output logic [31:0] hi_wdata,
   output logic [31:0] lo_wdata
);
   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
   state_t state, state_d;
   logic [1:0] op_q;
   logic [31:0] a_q, b_q, mb_q, dvd_q, rem_q;
   logic sa_q, sb_q;
   logic [4:0] cnt;
   logic accept, in_sa, in_sb, early, res, ge;
   logic [31:0] in_ma, in_mb, quo, rmd, div_hi, div_lo;
   logic [32:0] sh;
   logic [63:0] ma, mb, prod;
   assign accept = start_valid & ~flush;
   assign in_sa = ~op[0] & src_a[31];
   assign in_sb = ~op[0] & src_b[31];
   assign in_ma = in_sa ? -src_a : src_a;
   assign in_mb = in_sb ? -src_b : src_b;
`ifdef MULDIV_DIV_EARLY_EXIT_EN
   assign early = op[1] & ((src_b == '0) | (in_ma < in_mb));
`else
   assign early = 1'b0;
`endif
   assign sh = {rem_q, dvd_q[31]};
   assign ge = sh >= {1'b0, mb_q};
   assign ma = {{32{~op_q[0] & a_q[31]}}, a_q};
   assign mb = {{32{~op_q[0] & b_q[31]}}, b_q};
   assign prod = ma * mb;
   assign quo = (sa_q ^ sb_q) ? -dvd_q : dvd_q;
   assign rmd = sa_q ? -rem_q : rem_q;
   assign div_lo = (b_q == '0) ? '1 : quo;
   assign div_hi = (b_q == '0) ? a_q : rmd;
   // state register
   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else state <= state_d;
   end
   // next state and result-cycle detection; flush overrides everything
   always_comb begin
      state_d = state;
      res = 1'b0;
      case (state)
         IDLE: if (accept) state_d = op[1] ? (early ? FIX : DIV) : MUL;
         MUL: if (cnt == 5'd0) begin
            state_d = IDLE;
            res = 1'b1;
         end
         DIV: if (cnt == 5'd0) state_d = FIX;
         default: begin
            state_d = IDLE;
            res = 1'b1;
         end
      endcase
      if (flush) begin
         state_d = IDLE;
         res = 1'b0;
      end
   end
   assign busy = state != IDLE;
   assign done = res;
   assign hilo_we = res ? 2'b11 : {mt_we & mt_hi, mt_we & ~mt_hi};
   assign hi_wdata = res ? (op_q[1] ? div_hi : prod[63:32]) : mt_data;
   assign lo_wdata = res ? (op_q[1] ? div_lo : prod[31:0]) : mt_data;
   // operand capture, multiply countdown and one restoring divide step per cycle
   always_ff @(posedge clk) begin
      if (!resetn) begin
         op_q <= '0;
         a_q <= '0;
         b_q <= '0;
         mb_q <= '0;
         dvd_q <= '0;
         rem_q <= '0;
         sa_q <= 1'b0;
         sb_q <= 1'b0;
         cnt <= '0;
      end else if (state == IDLE) begin
         if (accept) begin
            op_q <= op;
            a_q <= src_a;
            b_q <= src_b;
            mb_q <= in_mb;
            sa_q <= in_sa;
            sb_q <= in_sb;
            dvd_q <= early ? '0 : in_ma;
            rem_q <= early ? in_ma : '0;
            cnt <= op[1] ? 5'd31 : 5'(MULT_LAT - 1);
         end
      end else if (state == MUL) begin
         cnt <= cnt - 5'd1;
      end else if (state == DIV) begin
         cnt <= cnt - 5'd1;
         rem_q <= ge ? 32'(sh - {1'b0, mb_q}) : sh[31:0];
         dvd_q <= {dvd_q[30:0], ge};
      end
   end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: scoreboard bench for muldiv_ctrl; expected writes are queued by the stimulus and popped by a monitor.
module tb_muldiv_ctrl;
   localparam int L = 3;
`ifdef MULDIV_DIV_EARLY_EXIT_EN
   localparam int EL = 1;
`else
   localparam int EL = 33;
`endif
   logic clk = 1'b0, resetn = 1'b0, start_valid = 1'b0, flush = 1'b0, mt_we = 1'b0, mt_hi = 1'b0;
   logic [1:0] op = 2'd0;
   logic [31:0] src_a = '0, src_b = '0, mt_data = '0;
   logic busy, done;
   logic [1:0] hilo_we;
   logic [31:0] hi_wdata, lo_wdata;
   int cyc = 0, checks = 0, errors = 0;
   typedef struct {
      int c;
      logic [1:0] we;
      logic [31:0] hi;
      logic [31:0] lo;
      logic d;
   } exp_t;
   exp_t exp_q[$];

   muldiv_ctrl #(.MULT_LAT(L)) dut (
      .clk(clk), .resetn(resetn), .start_valid(start_valid), .op(op), .src_a(src_a), .src_b(src_b),
      .flush(flush), .mt_we(mt_we), .mt_hi(mt_hi), .mt_data(mt_data), .busy(busy), .done(done),
      .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int c, input logic [1:0] we, input logic [31:0] hi, input logic [31:0] lo, input logic d);
      exp_t e;
      e.c = c; e.we = we; e.hi = hi; e.lo = lo; e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      start_valid = 1'b1; op = o; src_a = a; src_b = b;
      chk("busy_at_accept", {63'd0, busy}, 64'd0);
      tick();
      start_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60 && busy; i++) tick();
      chk("idle_timeout", {63'd0, busy}, 64'd0);
   endtask

   // monitor: every write or done must match the head of the expectation queue
   always @(negedge clk) begin
      if (hilo_we != 2'b00 || done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write cyc=%0d we=%b hi=%h lo=%h done=%b", cyc, hilo_we, hi_wdata, lo_wdata, done);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wr_cycle", 64'(cyc), 64'(e.c));
            chk("wr_we", {62'd0, hilo_we}, {62'd0, e.we});
            chk("wr_hi", {32'd0, hi_wdata}, {32'd0, e.hi});
            chk("wr_lo", {32'd0, lo_wdata}, {32'd0, e.lo});
            chk("wr_done", {63'd0, done}, {63'd0, e.d});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int c0;
      repeat (3) tick();
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_we", {62'd0, hilo_we}, 64'd0);
      chk("rst_hi", {32'd0, hi_wdata}, 64'd0);
      chk("rst_lo", {32'd0, lo_wdata}, 64'd0);
      resetn = 1'b1;
      tick();
      // MULT -2 * 3 with busy profile
      c0 = cyc;
      push(c0 + L, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1);
      start(2'd0, 32'hFFFF_FFFE, 32'd3);
      for (int i = 1; i <= L; i++) begin
         chk("mul_busy_high", {63'd0, busy}, 64'd1);
         tick();
      end
      chk("mul_busy_fall", {63'd0, busy}, 64'd0);
      // DIV -7 / 2
      push(cyc + 33, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
      start(2'd2, 32'hFFFF_FFF9, 32'd2);
      wait_idle();
      // DIVU 100 / 7
      push(cyc + 33, 2'b11, 32'd2, 32'd14, 1'b1);
      start(2'd3, 32'd100, 32'd7);
      wait_idle();
      // DIVU 5 / 0
      push(cyc + EL, 2'b11, 32'd5, 32'hFFFF_FFFF, 1'b1);
      start(2'd3, 32'd5, 32'd0);
      wait_idle();
      // DIV 7 / -2 and -8 / -3
      push(cyc + 33, 2'b11, 32'd1, 32'hFFFF_FFFD, 1'b1);
      start(2'd2, 32'd7, 32'hFFFF_FFFE);
      wait_idle();
      push(cyc + 33, 2'b11, 32'hFFFF_FFFE, 32'd2, 1'b1);
      start(2'd2, 32'hFFFF_FFF8, 32'hFFFF_FFFD);
      wait_idle();
      // DIV -3 / 7: small dividend, early-exit candidate
      push(cyc + EL, 2'b11, 32'hFFFF_FFFD, 32'd0, 1'b1);
      start(2'd2, 32'hFFFF_FFFD, 32'd7);
      wait_idle();
      // MULT min * min and MULTU max * max
      push(cyc + L, 2'b11, 32'h4000_0000, 32'h0, 1'b1);
      start(2'd0, 32'h8000_0000, 32'h8000_0000);
      wait_idle();
      push(cyc + L, 2'b11, 32'hFFFF_FFFE, 32'h1, 1'b1);
      start(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_idle();
      // DIV flushed in cycle 10, MULTU 4*5 accepted in cycle 11
      c0 = cyc;
      start(2'd2, 32'd100, 32'd3);
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_busy", {63'd0, busy}, 64'd0);
      chk("flush_cycle", 64'(cyc), 64'(c0 + 11));
      push(cyc + L, 2'b11, 32'd0, 32'd20, 1'b1);
      start(2'd1, 32'd4, 32'd5);
      wait_idle();
      // MULTU 2*3 colliding with MTLO, then a lone MTHI
      c0 = cyc;
      push(c0 + L, 2'b11, 32'd0, 32'd6, 1'b1);
      start(2'd1, 32'd2, 32'd3);
      repeat (L - 1) tick();
      mt_we = 1'b1; mt_hi = 1'b0; mt_data = 32'hA5;
      tick();
      push(cyc, 2'b10, 32'hA5, 32'hA5, 1'b0);
      mt_hi = 1'b1;
      tick();
      push(cyc, 2'b01, 32'h1234, 32'h1234, 1'b0);
      mt_hi = 1'b0; mt_data = 32'h1234;
      tick();
      mt_we = 1'b0; mt_data = '0;
      chk("mt_idle_busy", {63'd0, busy}, 64'd0);
      // flush on the mult result cycle keeps only the MTHI write
      c0 = cyc;
      start(2'd0, 32'd3, 32'd3);
      repeat (L - 1) tick();
      push(cyc, 2'b10, 32'h77, 32'h77, 1'b0);
      flush = 1'b1; mt_we = 1'b1; mt_hi = 1'b1; mt_data = 32'h77;
      tick();
      flush = 1'b0; mt_we = 1'b0; mt_hi = 1'b0; mt_data = '0;
      chk("flush_res_busy", {63'd0, busy}, 64'd0);
      // back-to-back: DIVU 9/2 in the first IDLE cycle after MULTU 7*6
      c0 = cyc;
      push(c0 + L, 2'b11, 32'd0, 32'd42, 1'b1);
      start(2'd1, 32'd7, 32'd6);
      wait_idle();
      chk("b2b_cycle", 64'(cyc), 64'(c0 + L + 1));
      push(cyc + 33, 2'b11, 32'd1, 32'd4, 1'b1);
      start(2'd3, 32'd9, 32'd2);
      wait_idle();
      // reset in cycle 15 of a DIV
      start(2'd2, 32'd1000, 32'd3);
      repeat (14) tick();
      resetn = 1'b0;
      tick();
      chk("rst_mid_busy", {63'd0, busy}, 64'd0);
      chk("rst_mid_we", {62'd0, hilo_we}, 64'd0);
      chk("rst_mid_hi", {32'd0, hi_wdata}, 64'd0);
      chk("rst_mid_lo", {32'd0, lo_wdata}, 64'd0);
      resetn = 1'b1;
      repeat (40) tick();
      chk("rst_mid_idle", {63'd0, busy}, 64'd0);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller for the shared HI/LO resource. Accepts MULT/MULTU/DIV/DIVU from execute, runs a counted multiply or a 32-iteration restoring divide, and owns the single HI/LO write port, merging results with MTHI/MTLO writes from writeback. `busy` feeds the hazard unit, which stalls any MFHI/MFLO or new mult/div in decode while an operation is in flight.

## Interface
Parameters:
- `MULT_LAT`, default 3: cycles in the MUL state, range 1..15.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `start_valid` in 1: execute holds a mult/div this cycle.
- `op` in 2: operation code. 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU.
- `src_a` in 32: rs operand (dividend).
- `src_b` in 32: rt operand (divisor).
- `flush` in 1: pipeline flush on an exception; cancels the operation.
- `mt_we` in 1: a MTHI/MTLO write is committing in writeback.
- `mt_hi` in 1: selects the half for `mt_we`. 1 = HI, 0 = LO.
- `mt_data` in 32: data for the MTHI/MTLO write.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse when a result is written.
- `hilo_we` out 2: write enables. Bit 1 = HI, bit 0 = LO.
- `hi_wdata` out 32: HI write data.
- `lo_wdata` out 32: LO write data.

## Operation
States: IDLE, MUL, DIV, FIX.

- **IDLE**
  - A start is accepted when `start_valid` is high and `flush` is low.
  - On accept, register `op`, `src_a` and `src_b`.
  - Mult ops go to MUL with the counter set to `MULT_LAT`-1.
  - Div ops register the operand magnitudes and the two signs, clear the partial remainder, and go to DIV with the counter set to 31.
  - `start_valid` while busy is ignored. The hazard unit guarantees it is held.
- **MUL**
  - Count down each cycle.
  - At count 0: write the 64-bit product (signed for MULT, unsigned for MULTU), HI = [63:32], LO = [31:0]. Assert `done`, return to IDLE.
- **DIV**
  - One restoring step per cycle, MSB first: shift the next dividend bit into the 33-bit partial remainder; subtract the divisor magnitude when the result is non-negative; shift the quotient bit in.
  - After the count-0 step, go to FIX.
- **FIX**
  - DIV: negate the quotient if the operand signs differ. The remainder takes the sign of the dividend.
  - Write LO = quotient, HI = remainder. Assert `done`, return to IDLE.
- **Divide by zero** (`src_b` = 0, any div op): the result is forced to LO = 32'hFFFF_FFFF, HI = `src_a`.
- **Write-port merge**
  - On a result cycle: `hilo_we` = 2'b11.
  - Otherwise: `hilo_we` = {`mt_we`&`mt_hi`, `mt_we`&~`mt_hi`}, and both data buses carry `mt_data`.
  - If a result and `mt_we` occur in the same cycle, the result wins both halves and the `mt` write is dropped.
- **Flush**
  - In any state, the next state is IDLE.
  - A flush on the result cycle suppresses the result write and `done`. The `mt` path is still honoured.
  - A flush in IDLE blocks an accept that cycle.
- **Reset**: state IDLE, counter 0, all registered operands 0.

## Timing
- Reset values: `busy` = 0, `done` = 0, `hilo_we` = 0, `hi_wdata` = 0, `lo_wdata` = 0 (no `mt_we`).
- Accept cycle = cycle 0. `busy` rises in cycle 1.
- Mult: result write, `done` and the last busy cycle all fall in cycle `MULT_LAT`.
- Div: DIV occupies cycles 1..32, FIX is cycle 33, so the write is in cycle 33.
- `busy` falls the cycle after the write. MFHI/MFLO issued then reads the updated value.
- `hilo_we`, `done` and the write data are combinational from the state, the registers and the `mt_*` inputs. There is no added latency on the `mt` path.
- A back-to-back start is accepted in the first IDLE cycle after the write.

## Configuration
- `MULDIV_DIV_EARLY_EXIT_EN` defined:
  - A div op with `src_b` = 0, or with |`src_a`| < |`src_b`|, skips DIV and goes straight from IDLE to FIX.
  - The write happens in cycle 1.
  - Quotient = 0 (or the divide-by-zero value); remainder = `src_a`.
- Undefined: every div op takes 33 cycles, bit-identical results.

## Test plan
- MULT, `src_a`=32'hFFFF_FFFE (-2), `src_b`=3, `MULT_LAT`=3 -> in cycle 3: `hilo_we`=11, HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA, `done` for 1 cycle; `busy` high in cycles 1..3.
- DIV, -7 / 2 -> in cycle 33: LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1). DIVU, 100 / 7 -> LO=14, HI=2.
- DIVU, 5 / 0 -> LO=32'hFFFF_FFFF, HI=5. Cycle 33 without the macro, cycle 1 with `MULDIV_DIV_EARLY_EXIT_EN`.
- DIV started, `flush` in cycle 10 -> `busy`=0 in cycle 11, no `hilo_we` or `done`. A new MULTU 4×5 accepted in cycle 11 -> LO=20, HI=0 in cycle 11+`MULT_LAT`.
- `mt_we`=1, `mt_hi`=0, `mt_data`=32'hA5 in the same cycle as a MULTU 2×3 result write -> `hilo_we`=11, LO=6, HI=0. Next cycle, a lone `mt_we` to HI -> `hilo_we`=10, HI=`mt_data`.
- `resetn` low in cycle 15 of a DIV -> next cycle: IDLE, `busy`=0, no write. Its outputs read 0 at reset.
